sha256_round_engine: RTL

Compression-round stage that sits directly upstream of the hash register block. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream and expands the message schedule on the fly. It runs the 64 SHA-256 rounds at one per clock, seeded from the current intermediate hash, then presents the final working variables A..H with a one-cycle `done` pulse that drives the hash register block's write enable.

---
 rtl/sha256_round_engine_pkg.sv | 75 +++++++
 rtl/sha256_round_engine_if.sv | 11 +
 rtl/sha256_schedule.sv | 40 ++++
 rtl/sha256_round_engine.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sha256_round_engine_pkg.sv
// Shared SHA-256 types, round constants and the sigma/choice/majority helpers
// used by the round engine and by later hash stages.
package sha256_round_engine_pkg;

    localparam int unsigned WORD   = 32;
    localparam int unsigned ROUNDS = 64;
    localparam int unsigned WIN    = 16;
    localparam int unsigned TW     = $clog2(ROUNDS);
    localparam int unsigned CW     = $clog2(WIN);

    typedef logic [WORD-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE
    } state_t;

    // Working variables A..H, A in the most significant slot
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    localparam word_t K_TABLE [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t k_const(input logic [TW-1:0] t);
        return K_TABLE[t];
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// Message word stream into the round engine (valid/ready).
interface sha256_round_engine_if;
    import sha256_round_engine_pkg::*;

    word_t msg_word;
    logic  msg_valid;
    logic  msg_ready;

    modport master (output msg_word, output msg_valid, input msg_ready);
    modport slave  (input msg_word, input msg_valid, output msg_ready);
endinterface

// File: rtl/sha256_schedule.sv
// 16-word message schedule window: shifts in loaded words, then expands
// one new word per round; wt is always the oldest entry.
module sha256_schedule
    import sha256_round_engine_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  step,
    input  word_t in_word,
    output word_t wt
);

    word_t w [WIN];
    word_t w_new;

    // Loaded word during LOAD, sigma expansion during rounds
    always_comb begin
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
        if (load) begin
            w_new = in_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                w[i] <= '0;
            end
        end else if (load || step) begin
            for (int i = 0; i < WIN - 1; i++) begin
                w[i] <= w[i+1];
            end
            w[WIN-1] <= w_new;
        end
    end

    assign wt = w[0];

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression stage: loads 16 message words, runs 64 rounds at one per
// clock from the current hash, then pulses done with final A..H.
module sha256_round_engine
    import sha256_round_engine_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_round_engine_if.slave  msg,
    input  logic                  abort,
    input  word_t                 hash0,
    input  word_t                 hash1,
    input  word_t                 hash2,
    input  word_t                 hash3,
    input  word_t                 hash4,
    input  word_t                 hash5,
    input  word_t                 hash6,
    input  word_t                 hash7,
    output word_t                 A,
    output word_t                 B,
    output word_t                 C,
    output word_t                 D,
    output word_t                 E,
    output word_t                 F,
    output word_t                 G,
    output word_t                 H,
    output logic                  busy,
    output logic                  done
);

    state_t          state, state_nxt;
    logic [CW-1:0]   wcnt;
    logic [TW-1:0]   t;
    logic            ready_q, busy_q, done_q;
    logic            accept, load_hash, do_round;
    work_t           work, round_nxt;
    word_t           wt, t1, t2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; abort overrides everything
    always_comb begin
        state_nxt = state;
        accept    = msg.msg_valid && ready_q;
        load_hash = 1'b0;
        do_round  = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                    if (wcnt == CW'(WIN - 1)) begin
                        state_nxt = ST_ROUND;
                        load_hash = 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                do_round = 1'b1;
                if (t == TW'(ROUNDS - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            accept    = 1'b0;
            load_hash = 1'b0;
            do_round  = 1'b0;
        end
    end

    sha256_schedule u_schedule (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    (do_round),
        .in_word (msg.msg_word),
        .wt      (wt)
    );

    always_comb begin
        t1 = work.h + big_sigma1(work.e) + ch(work.e, work.f, work.g) + k_const(t) + wt;
        t2 = big_sigma0(work.a) + maj(work.a, work.b, work.c);
        round_nxt = work_t'{t1 + t2, work.a, work.b, work.c, work.d + t1, work.e, work.f, work.g};
    end

    // Status flags are decoded from the next state so they track it registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt    <= '0;
            t       <= '0;
            work    <= '0;
        end else begin
            ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= (state_nxt == ST_DONE);
            if (abort) begin
                wcnt <= '0;
            end else if (accept) begin
                wcnt <= wcnt + CW'(1);
            end
            if (abort || load_hash) begin
                t <= '0;
            end else if (do_round) begin
                t <= t + TW'(1);
            end
            if (load_hash) begin
                work <= work_t'{hash0, hash1, hash2, hash3, hash4, hash5, hash6, hash7};
            end else if (do_round) begin
                work <= round_nxt;
            end
        end
    end

    assign msg.msg_ready = ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign A = work.a;
    assign B = work.b;
    assign C = work.c;
    assign D = work.d;
    assign E = work.e;
    assign F = work.f;
    assign G = work.g;
    assign H = work.h;

endmodule
